// File: rtl/mlp_train_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer_pkg
//   Shared definitions for the MLP stimulus sequencer:
//   - fixed-point section: sfp type (signed FP_W bits, FP_FRAC fractional bits)
//     with the ONE and HALF constants and a 0/1 -> 0/ONE helper;
//   - common section: the sequencer FSM state encoding.
// -----------------------------------------------------------------------------
package mlp_train_sequencer_pkg;

    // ---- fixed point ----
    localparam int FP_W    = 64;
    localparam int FP_FRAC = 32;

    typedef logic signed [FP_W-1:0] sfp;

    localparam sfp ONE  = sfp'(1) << FP_FRAC;
    localparam sfp HALF = sfp'(1) << (FP_FRAC - 1);

    // Maps a boolean to the fixed-point values the MLP expects on its inputs.
    function automatic sfp bit_to_sfp(input logic b);
        return b ? ONE : '0;
    endfunction

    // ---- common ----
    typedef enum logic [1:0] {
        TRAIN_LOAD,
        TRAIN_WAIT,
        INFER_LOAD,
        INFER_WAIT
    } seq_state_t;

endpackage

// File: rtl/mlp_train_sequencer_if.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer_if
//   Sample handshake between the sequencer and the MLP core.
//   sample_valid        : one-cycle strobe, values/expected/training are stable
//   values_0, values_1  : MLP inputs (0 or ONE)
//   expected            : training target (0 or ONE)
//   training            : MLP must update its weights on this sample
//   mlp_done            : one-cycle pulse, MLP finished the current sample
//   prediction          : MLP output[0], valid while mlp_done is high
//   master = sequencer side, slave = MLP side.
// -----------------------------------------------------------------------------
interface mlp_train_sequencer_if;
    import mlp_train_sequencer_pkg::*;

    logic sample_valid;
    sfp   values_0;
    sfp   values_1;
    sfp   expected;
    logic training;
    logic mlp_done;
    sfp   prediction;

    modport master (
        output sample_valid, values_0, values_1, expected, training,
        input  mlp_done, prediction
    );

    modport slave (
        input  sample_valid, values_0, values_1, expected, training,
        output mlp_done, prediction
    );

endinterface

// File: rtl/mlp_train_sequencer_switch_debouncer.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer_switch_debouncer
//   Brings one asynchronous board switch into the clk domain through a 2-flop
//   synchroniser, then only accepts a new level once the synchronised value has
//   differed from the accepted one for DEBOUNCE_CYCLES consecutive cycles.
//   clk, rst   : system clock, synchronous active-high reset
//   raw        : asynchronous switch input
//   debounced  : accepted switch level
// -----------------------------------------------------------------------------
module mlp_train_sequencer_switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic debounced
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            count     <= '0;
            debounced <= 1'b0;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
            // Any return to the accepted level restarts the stability window.
            if (sync_1 == debounced) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                debounced <= sync_1;
                count     <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mlp_train_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_train_sequencer
//   Control stage in front of the MLP core. Training phase replays the 4-row
//   truth table EPOCHS times with training=1; inference phase then feeds the
//   debounced switches forever and latches (prediction > HALF) onto the LED.
//   clk, rst       : system clock, synchronous active-high reset
//   first_input    : asynchronous switch 0 (drives values_0 in inference)
//   second_input   : asynchronous switch 1 (drives values_1 in inference)
//   mlp            : sample handshake to the MLP (master side)
//   epoch          : completed-epoch count, saturates at EPOCHS
//   training_done  : sticky, all epochs finished
//   output_led     : thresholded prediction of the last inference
// -----------------------------------------------------------------------------
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int         EPOCHS          = 10,
    parameter logic [3:0] TRUTH_TABLE     = 4'b1000,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        first_input,
    input  logic                        second_input,
    mlp_train_sequencer_if.master       mlp,
    output logic [15:0]                 epoch,
    output logic                        training_done,
    output logic                        output_led
);

    // With zero epochs there is nothing to train: start directly in inference.
    localparam seq_state_t  RESET_STATE = (EPOCHS == 0) ? INFER_LOAD : TRAIN_LOAD;
    localparam logic [15:0] EPOCH_MAX   = 16'(EPOCHS);

    seq_state_t state;
    seq_state_t state_next;
    logic [1:0] row;
    logic       switch_0;
    logic       switch_1;
    logic       last_sample;
    logic       load_train;
    logic       load_infer;
    logic       train_ack;
    logic       infer_ack;

    mlp_train_sequencer_switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_switch_0 (
        .clk       (clk),
        .rst       (rst),
        .raw       (first_input),
        .debounced (switch_0)
    );

    mlp_train_sequencer_switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_switch_1 (
        .clk       (clk),
        .rst       (rst),
        .raw       (second_input),
        .debounced (switch_1)
    );

    // The sample now in flight is the final row of the final epoch.
    assign last_sample = (row == 2'd3) && (epoch + 16'd1 == EPOCH_MAX);

    // ---- state register ----
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    // ---- next-state logic ----
    // NOTE: the default assignment at the top keeps every path assigned, so
    // this stays combinational instead of inferring a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            TRAIN_LOAD: state_next = TRAIN_WAIT;
            TRAIN_WAIT: if (mlp.mlp_done) state_next = last_sample ? INFER_LOAD : TRAIN_LOAD;
            INFER_LOAD: state_next = INFER_WAIT;
            INFER_WAIT: if (mlp.mlp_done) state_next = INFER_LOAD;
            default:    state_next = RESET_STATE;
        endcase
    end

    // ---- output decode ----
    // mlp_done is only acted on in a WAIT state; anywhere else it is dropped.
    always_comb begin
        load_train = (state == TRAIN_LOAD);
        load_infer = (state == INFER_LOAD);
        train_ack  = (state == TRAIN_WAIT) && mlp.mlp_done;
        infer_ack  = (state == INFER_WAIT) && mlp.mlp_done;
    end

    // ---- registered sample / status outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            mlp.sample_valid <= 1'b0;
            mlp.values_0     <= '0;
            mlp.values_1     <= '0;
            mlp.expected     <= '0;
            mlp.training     <= (EPOCHS != 0);
            epoch            <= '0;
            training_done    <= (EPOCHS == 0);
            output_led       <= 1'b0;
            row              <= '0;
        end else begin
            mlp.sample_valid <= load_train || load_infer;

            if (load_train) begin
                mlp.values_0 <= bit_to_sfp(row[0]);
                mlp.values_1 <= bit_to_sfp(row[1]);
                mlp.expected <= bit_to_sfp(TRUTH_TABLE[row]);
            end

            if (load_infer) begin
                mlp.values_0 <= bit_to_sfp(switch_0);
                mlp.values_1 <= bit_to_sfp(switch_1);
                mlp.expected <= '0;
            end

            if (train_ack) begin
                row <= row + 2'd1;   // 3 -> 0 wraps into the next epoch
                if (row == 2'd3 && epoch != EPOCH_MAX) epoch <= epoch + 16'd1;
                if (last_sample) begin
                    mlp.training  <= 1'b0;
                    training_done <= 1'b1;
                end
            end

            // Signed compare: negative predictions and exactly HALF give 0.
            if (infer_ack) output_led <= (mlp.prediction > HALF);
        end
    end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mlp_train_sequencer
//   Main DUT (EPOCHS=2): an MLP stand-in answers 3 cycles after every
//   sample_valid; a scoreboard derives every output each cycle from sample
//   counts, the truth table and a sliding-window switch model. A second DUT
//   (EPOCHS=0) is driven directly for the zero-epoch start-up behaviour.
// -----------------------------------------------------------------------------
module tb_mlp_train_sequencer;
    import mlp_train_sequencer_pkg::*;

    localparam int         EP = 2;
    localparam logic [3:0] TT = 4'b1000;
    localparam int         DB = 16;

    logic clk = 1'b1;
    logic rst = 1'b1;
    logic sw0 = 1'b0;
    logic sw1 = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] epoch,  epoch0;
    logic        training_done, done0;
    logic        output_led, led0;

    mlp_train_sequencer_if bus ();
    mlp_train_sequencer_if bus0 ();

    mlp_train_sequencer #(.EPOCHS(EP), .TRUTH_TABLE(TT), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .first_input(sw0), .second_input(sw1), .mlp(bus),
        .epoch(epoch), .training_done(training_done), .output_led(output_led)
    );

    mlp_train_sequencer #(.EPOCHS(0), .TRUTH_TABLE(TT), .DEBOUNCE_CYCLES(DB)) dut0 (
        .clk(clk), .rst(rst), .first_input(1'b0), .second_input(1'b0), .mlp(bus0),
        .epoch(epoch0), .training_done(done0), .output_led(led0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- scoreboard state ----------------
    int  m_done_cnt = 0;      // training samples completed since reset
    bit  m_out      = 1'b0;   // a sample is waiting for mlp_done
    bit  m_led      = 1'b0;
    bit  m_armed    = 1'b0;
    int  sv_timer   = 0;
    sfp  dq[$];               // directed inference predictions, used first

    // Values captured at each rising edge (inputs seen by the DUT).
    logic e_rst  = 1'b0;
    logic e_done = 1'b0;
    sfp   e_pred = '0;

    // Switch model: a level is accepted once the synchroniser has presented
    // 16 consecutive samples of it; the sync delays samples by two edges.
    logic [DB+1:0] h0 = '0, h1 = '0;
    logic acc0 = 1'b0, acc1 = 1'b0, acc0_pre = 1'b0, acc1_pre = 1'b0;

    always @(posedge clk) begin
        e_rst    = rst;
        e_done   = bus.mlp_done;
        e_pred   = bus.prediction;
        acc0_pre = acc0;
        acc1_pre = acc1;
        if (rst) begin
            h0 = '0; h1 = '0; acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            h0 = {h0[DB:0], sw0};
            h1 = {h1[DB:0], sw1};
            if (&h0[DB+1:2]) acc0 = 1'b1; else if (~|h0[DB+1:2]) acc0 = 1'b0;
            if (&h1[DB+1:2]) acc1 = 1'b1; else if (~|h1[DB+1:2]) acc1 = 1'b0;
        end
    end

    // ---------------- MLP stand-in for the main DUT ----------------
    function automatic sfp pick_pred();
        if (m_done_cnt >= 4 * EP && dq.size() > 0) return dq.pop_front();
        case ($urandom_range(0, 6))
            0:       return HALF;
            1:       return HALF + sfp'(1);
            2:       return HALF - sfp'(1);
            3:       return -ONE;
            4:       return sfp'(64'h0000_0000_C000_0000);
            default: return sfp'({$urandom(), $urandom()});
        endcase
    endfunction

    int cd = 0;
    always @(negedge clk) begin
        bus.mlp_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.mlp_done   = 1'b1;
                bus.prediction = pick_pred();
            end
        end
        if (bus.sample_valid === 1'b1) cd = 3;
    end

    initial bus.prediction = '0;

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin : monitor
        bit exp_sv;
        int r;
        exp_sv = 1'b0;
        if (e_rst) begin
            m_armed    = 1'b1;
            m_done_cnt = 0;
            m_out      = 1'b0;
            m_led      = 1'b0;
            sv_timer   = 1;
        end else if (m_armed) begin
            if (sv_timer == 1) begin
                exp_sv   = 1'b1;
                sv_timer = 0;
            end
            if (e_done && m_out) begin
                m_out    = 1'b0;
                sv_timer = 1;
                if (m_done_cnt < 4 * EP) m_done_cnt++;
                else                     m_led = (e_pred > HALF);
            end
        end
        if (m_armed) begin
            check("sample_valid",  64'(bus.sample_valid), 64'(exp_sv));
            check("epoch",         64'(epoch),            64'(m_done_cnt / 4));
            check("training_done", 64'(training_done),    64'(m_done_cnt >= 4 * EP));
            check("training",      64'(bus.training),     64'(m_done_cnt < 4 * EP));
            check("output_led",    64'(output_led),       64'(m_led));
            if (exp_sv) begin
                if (m_done_cnt < 4 * EP) begin
                    r = m_done_cnt % 4;
                    check("train_values_0", 64'(bus.values_0), 64'((r & 1) != 0 ? ONE : sfp'(0)));
                    check("train_values_1", 64'(bus.values_1), 64'((r & 2) != 0 ? ONE : sfp'(0)));
                    check("train_expected", 64'(bus.expected), 64'(TT[r]       ? ONE : sfp'(0)));
                end else begin
                    check("infer_values_0", 64'(bus.values_0), 64'(acc0_pre ? ONE : sfp'(0)));
                    check("infer_values_1", 64'(bus.values_1), 64'(acc1_pre ? ONE : sfp'(0)));
                    check("infer_expected", 64'(bus.expected), 64'(0));
                end
                m_out = 1'b1;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit hit;
        dq.push_back(sfp'(64'h0000_0000_C000_0000));  // 0.75 -> LED 1
        dq.push_back(HALF);                           // exactly HALF -> LED 0
        dq.push_back(-ONE);                           // -1.0 -> LED 0
        bus0.mlp_done   = 1'b0;
        bus0.prediction = '0;

        repeat (3) @(negedge clk);
        check("z_rst_training",      64'(bus0.training),     64'(0));
        check("z_rst_training_done", 64'(done0),             64'(1));
        check("z_rst_sample_valid",  64'(bus0.sample_valid), 64'(0));

        // Release reset; the zero-epoch DUT sits in INFER_LOAD this cycle,
        // so this mlp_done must be ignored.
        rst             = 1'b0;
        bus0.mlp_done   = 1'b1;
        bus0.prediction = ONE;
        @(negedge clk);
        bus0.mlp_done = 1'b0;
        check("z_first_sv",       64'(bus0.sample_valid), 64'(1));
        check("z_first_training", 64'(bus0.training),     64'(0));
        check("z_first_done",     64'(done0),             64'(1));
        check("z_first_values_0", 64'(bus0.values_0),     64'(0));
        check("z_first_led",      64'(led0),              64'(0));
        check("z_epoch",          64'(epoch0),            64'(0));
        @(negedge clk);
        bus0.prediction = sfp'(64'h0000_0000_C000_0000);
        bus0.mlp_done   = 1'b1;
        @(negedge clk);
        bus0.mlp_done = 1'b0;
        check("z_led_075", 64'(led0), 64'(1));
        @(negedge clk);
        bus0.prediction = HALF;
        bus0.mlp_done   = 1'b1;
        @(negedge clk);
        check("z_led_half", 64'(led0), 64'(0));
        bus0.prediction = ONE;        // lands in INFER_LOAD: ignored
        @(negedge clk);
        bus0.mlp_done = 1'b0;
        check("z_spurious_led", 64'(led0),              64'(0));
        check("z_spurious_sv",  64'(bus0.sample_valid), 64'(1));

        // Reset the main DUT in TRAIN_WAIT, epoch 1 row 2, with mlp_done high.
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (m_done_cnt == 6 && m_out && bus.mlp_done) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        check("rst_inject_reached", 64'(hit), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Full training run after the mid-transaction reset.
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = (m_done_cnt >= 4 * EP);
        end
        check("training_reached", 64'(hit), 64'(1));

        // Inference: both switches on, then random steady changes and glitches.
        sw0 = 1'b1;
        sw1 = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 70; i++) begin
            int  len;
            bit  which;
            which = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, 6);
                if (which) sw1 = ~sw1; else sw0 = ~sw0;
                repeat (len) @(negedge clk);
                if (which) sw1 = ~sw1; else sw0 = ~sw0;
                repeat (25) @(negedge clk);
            end else begin
                len = $urandom_range(14, 40);
                if (which) sw1 = ~sw1; else sw0 = ~sw0;
                repeat (len) @(negedge clk);
            end
        end
        repeat (30) @(negedge clk);
        check("directed_preds_used", 64'(dq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
